multdiv_issue: RTL and testbench

//  Pipeline-side initiator for the iterative mult/div unit. Captures a MUL/DIV from execute,

---
 rtl/multdiv_pkg.sv | 23 ++
 rtl/multdiv_issue_if.sv | 45 ++++
 rtl/md_watchdog.sv | 30 +++
 rtl/multdiv_issue.sv | 155 +++++++++++++++
 tb/tb_multdiv_issue.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the mult/div issue logic and the multdiv unit bench.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    localparam int MD_RSTATUS_REG = 30;
    localparam int MD_MULT_EXC    = 4;
    localparam int MD_DIV_EXC     = 5;
    localparam int MD_TMO_EXC     = 6;
    localparam int MD_TMO_CYCLES  = 64;
    localparam int MD_WDOG_W      = 7;

endpackage

// File: rtl/multdiv_issue_if.sv
// Execute-side request, multdiv unit handshake and regfile write port of the issue block.
interface multdiv_issue_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              ex_mult;
    logic              ex_div;
    logic [REG_W-1:0]  ex_rd;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic              flush;

    logic              ctrl_MULT;
    logic              ctrl_DIV;
    logic [DATA_W-1:0] data_operandA;
    logic [DATA_W-1:0] data_operandB;
    logic [DATA_W-1:0] data_result;
    logic              data_exception;
    logic              data_resultRDY;

    logic              stall;
    logic [REG_W-1:0]  busy_rd;

    logic              wb_valid;
    logic [REG_W-1:0]  wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ack;

    // Issue block view
    modport slave (
        input  ex_mult, ex_div, ex_rd, ex_a, ex_b, flush,
        input  data_result, data_exception, data_resultRDY, wb_ack,
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output stall, busy_rd, wb_valid, wb_addr, wb_data
    );

    // Pipeline / multdiv unit / regfile view
    modport master (
        output ex_mult, ex_div, ex_rd, ex_a, ex_b, flush,
        output data_result, data_exception, data_resultRDY, wb_ack,
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  stall, busy_rd, wb_valid, wb_addr, wb_data
    );

endinterface

// File: rtl/md_watchdog.sv
// Saturating cycle counter with synchronous clear; flags once LIMIT counted cycles elapse.
module md_watchdog #(
    parameter int CNT_W = 7,
    parameter int LIMIT = 64
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_cnt;

    // Holds at LIMIT so a long stall never wraps back into a false "not expired" state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT_V)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_timeout = (r_cnt == LIMIT_V);

endmodule

// File: rtl/multdiv_issue.sv
// Issues MUL/DIV to the iterative multdiv unit, stalls the pipeline while it runs,
// and writes the result (or an exception code to $rstatus) back through the regfile port.
module multdiv_issue
    import multdiv_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_W       = 5,
    parameter int RSTATUS_REG = MD_RSTATUS_REG,
    parameter int MULT_EXC    = MD_MULT_EXC,
    parameter int DIV_EXC     = MD_DIV_EXC,
    parameter int TMO_EXC     = MD_TMO_EXC,
    parameter int TMO_CYCLES  = MD_TMO_CYCLES
) (
    input  logic           clock,
    input  logic           reset_n,
    multdiv_issue_if.slave bus
);

    state_t            r_state;
    state_t            w_next;
    op_t               r_op;
    logic [REG_W-1:0]  r_rd;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [REG_W-1:0]  r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;

    logic              w_accept;
    logic              w_timeout;
    logic              w_wd_clr;
    logic              w_wd_en;
    logic              w_finish;
    logic              w_skip_wb;
    logic [REG_W-1:0]  w_res_addr;
    logic [DATA_W-1:0] w_res_data;

    logic              w_ctrl_mult;
    logic              w_ctrl_div;
    logic              w_stall;
    logic [REG_W-1:0]  w_busy_rd;
    logic              w_wb_valid;

    assign w_accept = (bus.ex_mult | bus.ex_div) & ~bus.flush;
    assign w_wd_clr = (r_state == START);
    assign w_wd_en  = (r_state == WAIT);

    md_watchdog #(
        .CNT_W (MD_WDOG_W),
        .LIMIT (TMO_CYCLES)
    ) u_watchdog (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_clr     (w_wd_clr),
        .i_en      (w_wd_en),
        .o_timeout (w_timeout)
    );

    // A WAIT cycle ends the operation on RDY or timeout unless flush squashes it; RDY beats timeout
    assign w_finish  = (r_state == WAIT) & ~bus.flush & (bus.data_resultRDY | w_timeout);
    assign w_skip_wb = bus.data_resultRDY & ~bus.data_exception & (r_rd == '0);

    always_comb begin
        w_res_addr = r_rd;
        w_res_data = bus.data_result;
        if (bus.data_resultRDY) begin
            if (bus.data_exception) begin
                w_res_addr = REG_W'(RSTATUS_REG);
                w_res_data = (r_op == OP_MULT) ? DATA_W'(MULT_EXC) : DATA_W'(DIV_EXC);
            end
        end else begin
            w_res_addr = REG_W'(RSTATUS_REG);
            w_res_data = DATA_W'(TMO_EXC);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = START;
            START:   w_next = bus.flush ? IDLE : WAIT;
            WAIT: begin
                if (bus.flush) begin
                    w_next = IDLE;
                end else if (w_finish) begin
                    w_next = (bus.data_resultRDY && w_skip_wb) ? IDLE : WB;
                end
            end
            // The write is already committed here, so flush has no effect
            WB:      if (bus.wb_ack) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_ctrl_mult = 1'b0;
        w_ctrl_div  = 1'b0;
        w_stall     = 1'b1;
        w_busy_rd   = r_rd;
        w_wb_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_stall   = 1'b0;
                w_busy_rd = '0;
            end
            START: begin
                w_ctrl_mult = (r_op == OP_MULT);
                w_ctrl_div  = (r_op == OP_DIV);
            end
            WB:      w_wb_valid = 1'b1;
            default: ;
        endcase
    end

    // Operands are captured on accept so they are already stable during the START pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op      <= OP_MULT;
            r_rd      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            if ((r_state == IDLE) && w_accept) begin
                r_op <= bus.ex_mult ? OP_MULT : OP_DIV;
                r_rd <= bus.ex_rd;
                r_a  <= bus.ex_a;
                r_b  <= bus.ex_b;
            end
            if (w_finish) begin
                r_wb_addr <= w_res_addr;
                r_wb_data <= w_res_data;
            end
        end
    end

    assign bus.ctrl_MULT     = w_ctrl_mult;
    assign bus.ctrl_DIV      = w_ctrl_div;
    assign bus.data_operandA = r_a;
    assign bus.data_operandB = r_b;
    assign bus.stall         = w_stall;
    assign bus.busy_rd       = w_busy_rd;
    assign bus.wb_valid      = w_wb_valid;
    assign bus.wb_addr       = r_wb_addr;
    assign bus.wb_data       = r_wb_data;

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed bench for multdiv_issue: one task per scenario with hand-computed expectations.
module tb_multdiv_issue;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    multdiv_issue_if #(.DATA_W(32), .REG_W(5)) bus ();

    multdiv_issue dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observations gathered by run_op
    int          o_mpulse, o_dpulse, o_stall_cnt, o_drop_k, o_wb_cycles, o_wb_first_k, o_ack_k, o_commits;
    logic        o_acc_stall, o_hold_ok, o_wb_stable;
    logic [4:0]  o_busy_start, o_busy_end, o_wb_addr;
    logic [31:0] o_wb_data;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ex_mult = 1'b0; bus.ex_div = 1'b0; bus.ex_rd = '0; bus.ex_a = '0; bus.ex_b = '0;
        bus.flush = 1'b0; bus.data_result = '0; bus.data_exception = 1'b0;
        bus.data_resultRDY = 1'b0; bus.wb_ack = 1'b0;
    endtask

    // k counts cycles from the START cycle (k=0); WAIT cycles are k=1,2,...
    task automatic run_op(input bit is_mul, input bit both, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b,
                          input int rdy_at, input logic [31:0] res, input bit exc,
                          input int ack_delay, input int flush_at, input int maxc);
        int wb_k;
        bus.ex_mult = is_mul | both; bus.ex_div = ~is_mul | both;
        bus.ex_rd = rd; bus.ex_a = a; bus.ex_b = b;
        o_acc_stall = bus.stall;
        step();
        bus.ex_mult = 1'b0; bus.ex_div = 1'b0; bus.ex_rd = 5'h1f; bus.ex_a = '1; bus.ex_b = '1;
        o_mpulse = 0; o_dpulse = 0; o_stall_cnt = 0; o_drop_k = -1; o_wb_cycles = 0;
        o_wb_first_k = -1; o_ack_k = -1; o_commits = 0; o_hold_ok = 1'b1; o_wb_stable = 1'b1;
        o_busy_start = bus.busy_rd; o_wb_addr = '0; o_wb_data = '0;
        wb_k = 0;
        for (int k = 0; k < maxc; k++) begin
            if (bus.ctrl_MULT) o_mpulse++;
            if (bus.ctrl_DIV) o_dpulse++;
            if (bus.stall) o_stall_cnt++;
            else if (o_drop_k < 0) o_drop_k = k;
            if (bus.stall && ((bus.data_operandA !== a) || (bus.data_operandB !== b))) o_hold_ok = 1'b0;
            bus.data_resultRDY = (k == rdy_at);
            bus.data_result    = (k == rdy_at) ? res : 32'hDEAD_BEEF;
            bus.data_exception = (k == rdy_at) ? exc : 1'b0;
            bus.flush          = (k == flush_at);
            if (bus.wb_valid) begin
                if (wb_k == 0) begin
                    o_wb_first_k = k; o_wb_addr = bus.wb_addr; o_wb_data = bus.wb_data;
                end else if ((bus.wb_addr !== o_wb_addr) || (bus.wb_data !== o_wb_data)) begin
                    o_wb_stable = 1'b0;
                end
                wb_k++;
                bus.wb_ack = (wb_k > ack_delay);
                if (bus.wb_ack) begin o_commits++; o_ack_k = k; end
            end else begin
                bus.wb_ack = 1'b0;
            end
            step();
        end
        o_wb_cycles = wb_k;
        o_busy_end = bus.busy_rd;
        idle_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) step();
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %0b want 0", bus.stall); end
        n_cmp++; if ({bus.ctrl_MULT, bus.ctrl_DIV} !== 2'b00) begin n_fail++; $display("FAIL rst_ctrl got %b want 00", {bus.ctrl_MULT, bus.ctrl_DIV}); end
        n_cmp++; if ({bus.wb_valid, bus.wb_addr, bus.wb_data} !== 38'd0) begin n_fail++; $display("FAIL rst_wb got %h want 0", {bus.wb_valid, bus.wb_addr, bus.wb_data}); end
        n_cmp++; if ({bus.data_operandA, bus.data_operandB, bus.busy_rd} !== 69'd0) begin n_fail++; $display("FAIL rst_operands got %h want 0", {bus.data_operandA, bus.data_operandB, bus.busy_rd}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_mul_basic();
        run_op(1, 0, 5'd3, 32'd7, 32'd6, 33, 32'd42, 0, 0, -1, 45);
        n_cmp++; if (o_acc_stall !== 1'b0) begin n_fail++; $display("FAIL mul_accept_stall got %0b want 0", o_acc_stall); end
        n_cmp++; if (o_mpulse !== 1 || o_dpulse !== 0) begin n_fail++; $display("FAIL mul_pulses got m=%0d d=%0d want m=1 d=0", o_mpulse, o_dpulse); end
        n_cmp++; if (o_stall_cnt !== 35) begin n_fail++; $display("FAIL mul_stall_cycles got %0d want 35", o_stall_cnt); end
        n_cmp++; if (o_wb_addr !== 5'd3 || o_wb_data !== 32'd42) begin n_fail++; $display("FAIL mul_wb got addr=%0d data=%0d want addr=3 data=42", o_wb_addr, o_wb_data); end
        n_cmp++; if (o_busy_start !== 5'd3 || o_busy_end !== 5'd0) begin n_fail++; $display("FAIL mul_busy_rd got %0d/%0d want 3/0", o_busy_start, o_busy_end); end
        n_cmp++; if (o_hold_ok !== 1'b1) begin n_fail++; $display("FAIL mul_operand_hold got %0b want 1", o_hold_ok); end
        n_cmp++; if (o_commits !== 1) begin n_fail++; $display("FAIL mul_commits got %0d want 1", o_commits); end
    endtask

    task automatic test_exceptions();
        run_op(0, 0, 5'd9, 32'd100, 32'd0, 20, 32'h1234, 1, 0, -1, 30);
        n_cmp++; if (o_dpulse !== 1 || o_mpulse !== 0) begin n_fail++; $display("FAIL div_pulses got m=%0d d=%0d want m=0 d=1", o_mpulse, o_dpulse); end
        n_cmp++; if (o_wb_addr !== 5'd30 || o_wb_data !== 32'd5) begin n_fail++; $display("FAIL div0_wb got addr=%0d data=%0d want addr=30 data=5", o_wb_addr, o_wb_data); end
        n_cmp++; if (o_commits !== 1 || o_wb_stable !== 1'b1) begin n_fail++; $display("FAIL div0_single_write got commits=%0d stable=%0b want 1/1", o_commits, o_wb_stable); end
        run_op(1, 0, 5'd5, 32'h4000_0000, 32'd4, 33, 32'h0, 1, 0, -1, 45);
        n_cmp++; if (o_wb_addr !== 5'd30 || o_wb_data !== 32'd4) begin n_fail++; $display("FAIL mul_ovf_wb got addr=%0d data=%0d want addr=30 data=4", o_wb_addr, o_wb_data); end
    endtask

    task automatic test_flush();
        bus.ex_mult = 1'b1; bus.flush = 1'b1; bus.ex_rd = 5'd2;
        step();
        idle_inputs();
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_on_accept got stall=%0b want 0", bus.stall); end
        run_op(1, 0, 5'd8, 32'd9, 32'd9, 30, 32'd81, 0, 0, 10, 40);
        n_cmp++; if (o_wb_cycles !== 0) begin n_fail++; $display("FAIL flush_wait_no_wb got %0d want 0", o_wb_cycles); end
        n_cmp++; if (o_drop_k !== 11) begin n_fail++; $display("FAIL flush_wait_stall_drop got k=%0d want 11", o_drop_k); end
        run_op(1, 0, 5'd7, 32'd3, 32'd5, 4, 32'd15, 0, 0, -1, 10);
        n_cmp++; if (o_mpulse !== 1 || o_wb_addr !== 5'd7 || o_wb_data !== 32'd15) begin n_fail++; $display("FAIL after_flush_op got m=%0d addr=%0d data=%0d want 1/7/15", o_mpulse, o_wb_addr, o_wb_data); end
        run_op(0, 0, 5'd6, 32'd8, 32'd2, 5, 32'd4, 0, 0, 0, 10);
        n_cmp++; if (o_drop_k !== 1 || o_wb_cycles !== 0) begin n_fail++; $display("FAIL flush_start got drop=%0d wb=%0d want 1/0", o_drop_k, o_wb_cycles); end
        run_op(1, 0, 5'd4, 32'd2, 32'd2, 8, 32'd4, 0, 0, 8, 14);
        n_cmp++; if (o_drop_k !== 9 || o_wb_cycles !== 0) begin n_fail++; $display("FAIL flush_vs_rdy got drop=%0d wb=%0d want 9/0", o_drop_k, o_wb_cycles); end
        run_op(1, 0, 5'd11, 32'd2, 32'd3, 5, 32'd6, 0, 2, 6, 14);
        n_cmp++; if (o_commits !== 1 || o_wb_addr !== 5'd11 || o_wb_data !== 32'd6) begin n_fail++; $display("FAIL flush_in_wb got commits=%0d addr=%0d data=%0d want 1/11/6", o_commits, o_wb_addr, o_wb_data); end
    endtask

    task automatic test_wb_backpressure();
        run_op(0, 0, 5'd12, 32'd50, 32'd7, 5, 32'd7, 0, 5, -1, 20);
        n_cmp++; if (o_wb_cycles !== 6 || o_wb_stable !== 1'b1) begin n_fail++; $display("FAIL bp_wb_hold got cycles=%0d stable=%0b want 6/1", o_wb_cycles, o_wb_stable); end
        n_cmp++; if (o_ack_k !== 11 || o_drop_k !== 12) begin n_fail++; $display("FAIL bp_idle_after_ack got ack=%0d drop=%0d want 11/12", o_ack_k, o_drop_k); end
        n_cmp++; if (o_wb_addr !== 5'd12 || o_wb_data !== 32'd7) begin n_fail++; $display("FAIL bp_wb got addr=%0d data=%0d want 12/7", o_wb_addr, o_wb_data); end
    endtask

    task automatic test_timeout_and_rd0();
        run_op(1, 0, 5'd13, 32'd1, 32'd1, -1, 32'd0, 0, 0, -1, 75);
        n_cmp++; if (o_wb_first_k !== 66) begin n_fail++; $display("FAIL tmo_wb_k got %0d want 66", o_wb_first_k); end
        n_cmp++; if (o_wb_addr !== 5'd30 || o_wb_data !== 32'd6) begin n_fail++; $display("FAIL tmo_wb got addr=%0d data=%0d want 30/6", o_wb_addr, o_wb_data); end
        run_op(1, 0, 5'd4, 32'd1, 32'd1, 65, 32'd123, 0, 0, -1, 75);
        n_cmp++; if (o_wb_addr !== 5'd4 || o_wb_data !== 32'd123) begin n_fail++; $display("FAIL rdy_beats_tmo got addr=%0d data=%0d want 4/123", o_wb_addr, o_wb_data); end
        run_op(0, 0, 5'd14, 32'd1, 32'd1, 0, 32'd77, 0, 0, -1, 75);
        n_cmp++; if (o_wb_data !== 32'd6 || o_wb_first_k !== 66) begin n_fail++; $display("FAIL rdy_in_start_ignored got data=%0d k=%0d want 6/66", o_wb_data, o_wb_first_k); end
        run_op(1, 0, 5'd0, 32'd2, 32'd3, 5, 32'd6, 0, 0, -1, 12);
        n_cmp++; if (o_wb_cycles !== 0 || o_drop_k !== 6) begin n_fail++; $display("FAIL rd0_skip got wb=%0d drop=%0d want 0/6", o_wb_cycles, o_drop_k); end
        run_op(1, 1, 5'd1, 32'd2, 32'd2, 3, 32'd4, 0, 0, -1, 8);
        n_cmp++; if (o_mpulse !== 1 || o_dpulse !== 0) begin n_fail++; $display("FAIL mult_priority got m=%0d d=%0d want 1/0", o_mpulse, o_dpulse); end
    endtask

    task automatic test_reset_midop();
        logic seen;
        bus.ex_div = 1'b1; bus.ex_rd = 5'd12; bus.ex_a = 32'd11; bus.ex_b = 32'd13;
        step();
        idle_inputs();
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.stall, bus.busy_rd, bus.data_operandA, bus.wb_valid} !== 39'd0) begin n_fail++; $display("FAIL midop_reset_outputs got %h want 0", {bus.stall, bus.busy_rd, bus.data_operandA, bus.wb_valid}); end
        step();
        rst_n = 1'b1;
        bus.data_resultRDY = 1'b1; bus.data_result = 32'd99;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            bus.data_resultRDY = 1'b0;
            if (bus.wb_valid || bus.ctrl_MULT || bus.ctrl_DIV || bus.stall) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midop_reset_quiet got activity=%0b want 0", seen); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_mul_basic();
        test_exceptions();
        test_flush();
        test_wb_backpressure();
        test_timeout_and_rd0();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
